// File: rtl/rf_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// rf_writeback_arbiter
//
// Write-port controller for the 32x32 register file. It arbitrates the single
// write port between the single-cycle ALU result path and the long-latency
// LSU. It also keeps a per-register scoreboard of destinations that still
// have an LSU write outstanding, and holds issue on RAW/WAW hazards against
// those destinations.
//
// Parameters
//   DATA_W  write-back data width
//   REG_AW  register address width (2**REG_AW registers)
//   FAIR    1 = round-robin between ALU and LSU, 0 = ALU always wins
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   alu_valid/alu_reg/alu_data    ALU write-back request
//   alu_ready                     ALU request accepted this cycle (comb)
//   lsu_valid/lsu_reg/lsu_data    LSU write-back request
//   lsu_ready                     LSU request accepted this cycle (comb)
//   issue_valid/issue_long        instruction at issue, long = LSU write-back
//   issue_dst/issue_src_a/_b      register operands of the issuing instruction
//   issue_stall                   hold issue this cycle (comb)
//   wb_en/wb_reg/wb_data          registered register-file write port
//   pending_count                 number of busy scoreboard entries
// -----------------------------------------------------------------------------
module rf_writeback_arbiter #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int FAIR   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   input  logic [REG_AW-1:0] alu_reg,
   input  logic [DATA_W-1:0] alu_data,
   output logic              alu_ready,
   input  logic              lsu_valid,
   input  logic [REG_AW-1:0] lsu_reg,
   input  logic [DATA_W-1:0] lsu_data,
   output logic              lsu_ready,
   input  logic              issue_valid,
   input  logic              issue_long,
   input  logic [REG_AW-1:0] issue_dst,
   input  logic [REG_AW-1:0] issue_src_a,
   input  logic [REG_AW-1:0] issue_src_b,
   output logic              issue_stall,
   output logic              wb_en,
   output logic [REG_AW-1:0] wb_reg,
   output logic [DATA_W-1:0] wb_data,
   output logic [REG_AW:0]   pending_count
);

   localparam int NREG = 1 << REG_AW;

   typedef enum logic {
      GNT_ALU = 1'b0,
      GNT_LSU = 1'b1
   } grant_e;

   grant_e              last_grant_q, last_grant_d;
   logic                alu_gnt, lsu_gnt, xfer;
   logic [REG_AW-1:0]   sel_reg;
   logic [DATA_W-1:0]   sel_data;

   logic                wb_en_q, wb_en_d;
   logic [REG_AW-1:0]   wb_reg_q, wb_reg_d;
   logic [DATA_W-1:0]   wb_data_q, wb_data_d;

   logic [NREG-1:0]     busy_q, busy_d;
   logic [REG_AW:0]     count_q, count_d;
   logic                issue_accept;

   // Population count of the scoreboard; entry 0 is always clear, so the
   // result never exceeds NREG-1 and fits in REG_AW+1 bits.
   function automatic logic [REG_AW:0] popcount(input logic [NREG-1:0] v);
      logic [REG_AW:0] cnt;
      cnt = '0;
      for (int i = 0; i < NREG; i++) begin
         cnt = cnt + {{REG_AW{1'b0}}, v[i]};
      end
      return cnt;
   endfunction

   // Grant decision. Contention is resolved by FAIR: round-robin hands the
   // port to whichever side did not win the last transfer.
   always_comb begin
      alu_gnt = 1'b0;
      lsu_gnt = 1'b0;
      if (alu_valid && lsu_valid) begin
         if (FAIR != 0) begin
            alu_gnt = (last_grant_q == GNT_LSU);
         end else begin
            alu_gnt = 1'b1;
         end
         lsu_gnt = !alu_gnt;
      end else begin
         alu_gnt = alu_valid;
         lsu_gnt = lsu_valid;
      end
   end

   assign alu_ready = alu_gnt;
   assign lsu_ready = lsu_gnt;
   assign xfer      = alu_gnt || lsu_gnt;
   assign sel_reg   = lsu_gnt ? lsu_reg  : alu_reg;
   assign sel_data  = lsu_gnt ? lsu_data : alu_data;

   // Round-robin state only moves when something is actually transferred.
   always_comb begin
      last_grant_d = last_grant_q;
      if (alu_gnt) begin
         last_grant_d = GNT_ALU;
      end else if (lsu_gnt) begin
         last_grant_d = GNT_LSU;
      end
   end

   // Output register next state. Writes to $zero are accepted but never
   // enable the register file; reg/data hold their value when idle.
   always_comb begin
      wb_en_d   = xfer && (sel_reg != '0);
      wb_reg_d  = wb_reg_q;
      wb_data_d = wb_data_q;
      if (xfer) begin
         wb_reg_d  = sel_reg;
         wb_data_d = sel_data;
      end
   end

   // Hazard check looks only at registered busy state: an LSU write landing
   // this cycle releases the stall one cycle later, there is no bypass.
   assign issue_stall = issue_valid &&
                        (busy_q[issue_src_a] || busy_q[issue_src_b] ||
                         (issue_long && busy_q[issue_dst]));

   assign issue_accept = issue_valid && issue_long && !issue_stall &&
                         (issue_dst != '0);

   // Scoreboard next state: clear on LSU completion, then set on a new
   // long-latency issue so that a same-cycle set on the same entry wins.
   always_comb begin
      busy_d = busy_q;
      if (lsu_gnt) begin
         busy_d[lsu_reg] = 1'b0;
      end
      if (issue_accept) begin
         busy_d[issue_dst] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   assign count_d = popcount(busy_d);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_q <= GNT_LSU;
         wb_en_q      <= 1'b0;
         wb_reg_q     <= '0;
         wb_data_q    <= '0;
         busy_q       <= '0;
         count_q      <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         wb_en_q      <= wb_en_d;
         wb_reg_q     <= wb_reg_d;
         wb_data_q    <= wb_data_d;
         busy_q       <= busy_d;
         count_q      <= count_d;
      end
   end

   assign wb_en         = wb_en_q;
   assign wb_reg        = wb_reg_q;
   assign wb_data       = wb_data_q;
   assign pending_count = count_q;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// Directed bench for rf_writeback_arbiter. Two instances share all inputs:
// u_fair (FAIR=1) and u_fix (FAIR=0). Inputs change on the falling edge;
// combinational outputs are sampled 1 ns later, registered outputs 1 ns after
// the rising edge.
// -----------------------------------------------------------------------------
module tb_rf_writeback_arbiter;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              alu_valid, lsu_valid;
   logic [REG_AW-1:0] alu_reg, lsu_reg;
   logic [DATA_W-1:0] alu_data, lsu_data;
   logic              issue_valid, issue_long;
   logic [REG_AW-1:0] issue_dst, issue_src_a, issue_src_b;

   logic              f_alu_ready, f_lsu_ready, f_stall, f_wb_en;
   logic [REG_AW-1:0] f_wb_reg;
   logic [DATA_W-1:0] f_wb_data;
   logic [REG_AW:0]   f_pend;

   logic              x_alu_ready, x_lsu_ready, x_stall, x_wb_en;
   logic [REG_AW-1:0] x_wb_reg;
   logic [DATA_W-1:0] x_wb_data;
   logic [REG_AW:0]   x_pend;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   rf_writeback_arbiter #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FAIR(1)) u_fair (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(f_alu_ready),
      .lsu_valid(lsu_valid), .lsu_reg(lsu_reg), .lsu_data(lsu_data), .lsu_ready(f_lsu_ready),
      .issue_valid(issue_valid), .issue_long(issue_long), .issue_dst(issue_dst),
      .issue_src_a(issue_src_a), .issue_src_b(issue_src_b), .issue_stall(f_stall),
      .wb_en(f_wb_en), .wb_reg(f_wb_reg), .wb_data(f_wb_data), .pending_count(f_pend)
   );

   rf_writeback_arbiter #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FAIR(0)) u_fix (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(x_alu_ready),
      .lsu_valid(lsu_valid), .lsu_reg(lsu_reg), .lsu_data(lsu_data), .lsu_ready(x_lsu_ready),
      .issue_valid(issue_valid), .issue_long(issue_long), .issue_dst(issue_dst),
      .issue_src_a(issue_src_a), .issue_src_b(issue_src_b), .issue_stall(x_stall),
      .wb_en(x_wb_en), .wb_reg(x_wb_reg), .wb_data(x_wb_data), .pending_count(x_pend)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic idle_inputs();
      alu_valid   = 1'b0; alu_reg  = '0; alu_data = '0;
      lsu_valid   = 1'b0; lsu_reg  = '0; lsu_data = '0;
      issue_valid = 1'b0; issue_long = 1'b0;
      issue_dst   = '0; issue_src_a = '0; issue_src_b = '0;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic comb_settle();
      #1;
   endtask

   task automatic after_pos();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset and idle
      idle_inputs();
      rst = 1'b1;
      at_neg();
      at_neg();
      rst = 1'b0;
      comb_settle();
      chk("rst_wb_en",   f_wb_en,   0);
      chk("rst_wb_reg",  f_wb_reg,  0);
      chk("rst_wb_data", f_wb_data, 0);
      chk("rst_pending", f_pend,    0);
      issue_valid = 1'b1; issue_src_a = 5'd3; issue_src_b = 5'd7; issue_dst = 5'd4;
      comb_settle();
      chk("rst_stall", f_stall, 0);
      after_pos();
      chk("idle_wb_en", f_wb_en, 0);

      // ALU-only write
      at_neg();
      idle_inputs();
      alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'hDEADBEEF;
      comb_settle();
      chk("alu_only_alu_ready", f_alu_ready, 1);
      chk("alu_only_lsu_ready", f_lsu_ready, 0);
      after_pos();
      chk("alu_only_wb_en",   f_wb_en,   1);
      chk("alu_only_wb_reg",  f_wb_reg,  5);
      chk("alu_only_wb_data", f_wb_data, 32'hDEADBEEF);
      at_neg();
      idle_inputs();
      after_pos();
      chk("alu_only_wb_en_off", f_wb_en,   0);
      chk("alu_only_hold_reg",  f_wb_reg,  5);
      chk("alu_only_hold_data", f_wb_data, 32'hDEADBEEF);

      // LSU-only write, leaves last_grant = LSU on both instances
      at_neg();
      lsu_valid = 1'b1; lsu_reg = 5'd10; lsu_data = 32'h0000AAAA;
      comb_settle();
      chk("lsu_only_lsu_ready", f_lsu_ready, 1);
      chk("lsu_only_alu_ready", f_alu_ready, 0);
      after_pos();
      chk("lsu_only_wb_reg",  f_wb_reg,  10);
      chk("lsu_only_wb_data", f_wb_data, 32'h0000AAAA);

      // Contention for four cycles
      at_neg();
      alu_valid = 1'b1; alu_reg = 5'd1; alu_data = 32'h11;
      lsu_valid = 1'b1; lsu_reg = 5'd2; lsu_data = 32'h22;
      for (int c = 0; c < 4; c++) begin
         comb_settle();
         chk($sformatf("fair_alu_ready_c%0d", c), f_alu_ready, (c % 2 == 0) ? 1 : 0);
         chk($sformatf("fair_lsu_ready_c%0d", c), f_lsu_ready, (c % 2 == 0) ? 0 : 1);
         chk($sformatf("fix_alu_ready_c%0d", c),  x_alu_ready, 1);
         chk($sformatf("fix_lsu_ready_c%0d", c),  x_lsu_ready, 0);
         after_pos();
         chk($sformatf("fair_wb_reg_c%0d", c),  f_wb_reg,  (c % 2 == 0) ? 1 : 2);
         chk($sformatf("fair_wb_data_c%0d", c), f_wb_data, (c % 2 == 0) ? 32'h11 : 32'h22);
         chk($sformatf("fix_wb_reg_c%0d", c),   x_wb_reg,  1);
         at_neg();
      end

      // Write to $zero is accepted but suppressed
      idle_inputs();
      alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'h1234;
      comb_settle();
      chk("zero_alu_ready", f_alu_ready, 1);
      after_pos();
      chk("zero_wb_en_fair", f_wb_en, 0);
      chk("zero_wb_en_fix",  x_wb_en, 0);

      // Scoreboard: long issue to r8
      at_neg();
      idle_inputs();
      issue_valid = 1'b1; issue_long = 1'b1; issue_dst = 5'd8;
      issue_src_a = 5'd1; issue_src_b = 5'd2;
      comb_settle();
      chk("sb_issue8_stall", f_stall, 0);
      after_pos();
      chk("sb_pending_1", f_pend, 1);
      chk("sb_pending_1_fix", x_pend, 1);
      at_neg();
      issue_long = 1'b0; issue_dst = 5'd4; issue_src_a = 5'd8; issue_src_b = 5'd3;
      comb_settle();
      chk("sb_raw_src_a_stall", f_stall, 1);
      issue_src_a = 5'd3; issue_src_b = 5'd8;
      comb_settle();
      chk("sb_raw_src_b_stall", f_stall, 1);
      issue_long = 1'b1; issue_dst = 5'd8; issue_src_a = 5'd1; issue_src_b = 5'd2;
      comb_settle();
      chk("sb_waw_stall", f_stall, 1);
      issue_long = 1'b0;
      comb_settle();
      chk("sb_short_dst8_no_stall", f_stall, 0);
      after_pos();
      chk("sb_pending_still_1", f_pend, 1);

      // LSU completes r8 while a dependent instruction waits
      at_neg();
      issue_long = 1'b0; issue_dst = 5'd4; issue_src_a = 5'd8; issue_src_b = 5'd3;
      lsu_valid = 1'b1; lsu_reg = 5'd8; lsu_data = 32'h88;
      comb_settle();
      chk("sb_clear_lsu_ready", f_lsu_ready, 1);
      chk("sb_no_bypass_stall", f_stall, 1);
      after_pos();
      chk("sb_released_stall", f_stall, 0);
      chk("sb_pending_0", f_pend, 0);
      chk("sb_clear_wb_reg", f_wb_reg, 8);

      // Same-cycle clear and set of r9: set wins
      at_neg();
      idle_inputs();
      lsu_valid = 1'b1; lsu_reg = 5'd9; lsu_data = 32'h99;
      issue_valid = 1'b1; issue_long = 1'b1; issue_dst = 5'd9;
      issue_src_a = 5'd1; issue_src_b = 5'd2;
      comb_settle();
      chk("setclr_stall", f_stall, 0);
      chk("setclr_lsu_ready", f_lsu_ready, 1);
      after_pos();
      chk("setclr_pending", f_pend, 1);
      chk("setclr_wb_reg", f_wb_reg, 9);
      at_neg();
      idle_inputs();
      issue_valid = 1'b1; issue_src_a = 5'd9; issue_src_b = 5'd2; issue_dst = 5'd4;
      comb_settle();
      chk("setclr_busy9_stall", f_stall, 1);

      // Write held in the output register, then reset mid-stream
      alu_valid = 1'b1; alu_reg = 5'd6; alu_data = 32'h66;
      after_pos();
      chk("held_wb_en", f_wb_en, 1);
      chk("held_wb_reg", f_wb_reg, 6);
      at_neg();
      alu_valid = 1'b0;
      rst = 1'b1;
      comb_settle();
      chk("midrst_wb_en", f_wb_en, 0);
      chk("midrst_pending", f_pend, 0);
      chk("midrst_stall", f_stall, 0);
      after_pos();
      chk("midrst_wb_en_next", f_wb_en, 0);
      chk("midrst_wb_data", f_wb_data, 0);
      at_neg();
      rst = 1'b0;
      idle_inputs();
      after_pos();
      chk("post_rst_wb_en", f_wb_en, 0);
      chk("post_rst_pending", x_pend, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
